msrv32_dmem_ctrl: RTL and testbench

//  Sequences one data-memory load/store at a time between the pipeline and the AHB-style data port.

---
 rtl/msrv32_dmem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_msrv32_dmem_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msrv32_dmem_ctrl                                             |
// | Description : Single-outstanding data-memory controller. Captures one      |
// |               load/store from the pipeline, runs the address and data      |
// |               phases on an AHB-style port (wait states, error response,    |
// |               timeout), builds byte-lane mask/data for stores, aligns and  |
// |               sign/zero-extends load data, and stalls the pipeline while   |
// |               busy.                                                        |
// | Option      : define MSRV32_MISALIGN_TRAP_EN to trap misaligned accesses   |
// |               (IDLE->DONE with error, adds misalign_out); otherwise low    |
// |               address bits are forced to natural alignment.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msrv32_dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_write_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  output logic        dmem_req_out,
  output logic [31:0] dmem_addr_out,
  output logic        dmem_wr_out,
  output logic [3:0]  dmem_wmask_out,
  output logic [31:0] dmem_wdata_out,
  input  logic        dmem_ready_in,
  input  logic        dmem_resp_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_data_out,
  output logic        rsp_err_out,
`ifdef MSRV32_MISALIGN_TRAP_EN
  output logic        misalign_out,
`endif
  output logic        stall_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A zero TIMEOUT_CYCLES disables the timeout entirely.
  localparam logic                 C_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] C_TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state, w_next;
  logic [31:0]          r_addr, r_wdata, r_rsp_data;
  logic [3:0]           r_mask;
  logic [1:0]           r_size;
  logic                 r_uns, r_write, r_rsp_err;
  logic [TIMEOUT_W-1:0] r_tcnt;
  logic                 w_accept, w_trap, w_timeout;
  logic [31:0]          w_addr_al, w_wdata, w_load;
  logic [3:0]           w_mask;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;

  assign w_accept  = req_ready_out & req_valid_in;
  assign w_timeout = C_TO_EN & (r_tcnt == C_TO_LAST);

`ifdef MSRV32_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap = ((req_size_in == 2'b01) & req_addr_in[0]) |
                  (req_size_in[1] & (req_addr_in[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Request-side shaping: natural alignment, byte-lane mask and replicated store data.
  always_comb begin
    w_addr_al = req_addr_in;
    w_mask    = 4'b0000;
    w_wdata   = req_wdata_in;
    if (req_size_in[1]) begin
      w_addr_al[1:0] = 2'b00;
      w_mask         = 4'b1111;
    end else if (req_size_in[0]) begin
      w_addr_al[0] = 1'b0;
      w_mask       = 4'b0011 << {req_addr_in[1], 1'b0};
      w_wdata      = {2{req_wdata_in[15:0]}};
    end else begin
      w_mask  = 4'b0001 << req_addr_in[1:0];
      w_wdata = {4{req_wdata_in[7:0]}};
    end
    if (!req_write_in) w_mask = 4'b0000;
  end

  // Load-side lane selection and sign/zero extension of the returned word.
  always_comb begin
    case (r_addr[1:0])
      2'd1:    w_byte = dmem_rdata_in[15:8];
      2'd2:    w_byte = dmem_rdata_in[23:16];
      2'd3:    w_byte = dmem_rdata_in[31:24];
      default: w_byte = dmem_rdata_in[7:0];
    endcase
    w_half = r_addr[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    w_load = dmem_rdata_in;
    if (r_size == 2'b00)
      w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
    else if (r_size == 2'b01)
      w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; ready in the final timeout cycle takes priority.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_trap ? S_DONE : S_REQ;
      S_REQ:   if (dmem_ready_in) w_next = S_WAIT;
               else if (w_timeout) w_next = S_DONE;
      S_WAIT:  if (dmem_ready_in || w_timeout) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_write    <= 1'b0;
      r_tcnt     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
`ifdef MSRV32_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr     <= w_addr_al;
          r_wdata    <= w_wdata;
          r_mask     <= w_mask;
          r_size     <= req_size_in;
          r_uns      <= req_unsigned_in;
          r_write    <= req_write_in;
          r_tcnt     <= '0;
          r_rsp_data <= '0;
          r_rsp_err  <= w_trap;
`ifdef MSRV32_MISALIGN_TRAP_EN
          r_misalign <= w_trap;
`endif
        end
        S_REQ: begin
          r_tcnt <= r_tcnt + TIMEOUT_W'(1);
          if (!dmem_ready_in && w_timeout) r_rsp_err <= 1'b1;
        end
        S_WAIT: begin
          r_tcnt <= r_tcnt + TIMEOUT_W'(1);
          if (dmem_ready_in) begin
            r_rsp_data <= (dmem_resp_in || r_write) ? 32'd0 : w_load;
            r_rsp_err  <= dmem_resp_in;
          end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_out  = (r_state == S_IDLE) & ~rst_in;
  assign dmem_req_out   = (r_state == S_REQ);
  assign dmem_addr_out  = r_addr;
  assign dmem_wr_out    = r_write;
  assign dmem_wmask_out = r_mask;
  assign dmem_wdata_out = r_wdata;
  assign rsp_valid_out  = (r_state == S_DONE);
  assign rsp_data_out   = (r_state == S_DONE) ? r_rsp_data : 32'd0;
  assign rsp_err_out    = (r_state == S_DONE) & r_rsp_err;
  assign stall_out      = ~rst_in & ((r_state == S_REQ) | (r_state == S_WAIT) |
                                     ((r_state == S_IDLE) & req_valid_in));
`ifdef MSRV32_MISALIGN_TRAP_EN
  assign misalign_out   = (r_state == S_DONE) & r_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msrv32_dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msrv32_dmem_ctrl                                          |
// | Description : Table-driven bench for msrv32_dmem_ctrl, plus hand-written   |
// |               reset-in-WAIT and timeout sequences (second instance with    |
// |               TIMEOUT_CYCLES=4). Honours MSRV32_MISALIGN_TRAP_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_msrv32_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_write, req_unsigned, dmem_ready, dmem_resp;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, dmem_rdata;
  logic        req_ready, dreq, dwr, rsp_valid, rsp_err, stall, misalign;
  logic [31:0] daddr, dwdata, rsp_data;
  logic [3:0]  dmask;
  logic        t_valid, t_ready;
  logic        t_req_ready, t_dreq, t_dwr, t_rsp_valid, t_rsp_err, t_stall, t_misalign;
  logic [31:0] t_daddr, t_dwdata, t_rsp_data;
  logic [3:0]  t_dmask;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  msrv32_dmem_ctrl dut (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_write_in(req_write), .req_size_in(req_size), .req_unsigned_in(req_unsigned),
    .req_addr_in(req_addr), .req_wdata_in(req_wdata), .dmem_req_out(dreq),
    .dmem_addr_out(daddr), .dmem_wr_out(dwr), .dmem_wmask_out(dmask),
    .dmem_wdata_out(dwdata), .dmem_ready_in(dmem_ready), .dmem_resp_in(dmem_resp),
    .dmem_rdata_in(dmem_rdata), .rsp_valid_out(rsp_valid), .rsp_data_out(rsp_data),
    .rsp_err_out(rsp_err),
`ifdef MSRV32_MISALIGN_TRAP_EN
    .misalign_out(misalign),
`endif
    .stall_out(stall)
  );

  msrv32_dmem_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut_to (
    .clk_in(clk), .rst_in(rst), .req_valid_in(t_valid), .req_ready_out(t_req_ready),
    .req_write_in(req_write), .req_size_in(req_size), .req_unsigned_in(req_unsigned),
    .req_addr_in(req_addr), .req_wdata_in(req_wdata), .dmem_req_out(t_dreq),
    .dmem_addr_out(t_daddr), .dmem_wr_out(t_dwr), .dmem_wmask_out(t_dmask),
    .dmem_wdata_out(t_dwdata), .dmem_ready_in(t_ready), .dmem_resp_in(dmem_resp),
    .dmem_rdata_in(dmem_rdata), .rsp_valid_out(t_rsp_valid), .rsp_data_out(t_rsp_data),
    .rsp_err_out(t_rsp_err),
`ifdef MSRV32_MISALIGN_TRAP_EN
    .misalign_out(t_misalign),
`endif
    .stall_out(t_stall)
  );

`ifndef MSRV32_MISALIGN_TRAP_EN
  assign misalign   = 1'b0;
  assign t_misalign = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    int          rqw, wtw, resp_mode;
    int          lat, nreq;
    logic [31:0] eaddr;
    logic        ewr;
    logic [3:0]  emask;
    logic [31:0] ewdata, edata;
    logic        eerr, emis;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int rqw, int wtw,
                              int resp_mode, int lat, int nreq, logic [31:0] eaddr,
                              logic ewr, logic [3:0] emask, logic [31:0] ewdata,
                              logic [31:0] edata, logic eerr, logic emis);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rqw = rqw; v.wtw = wtw; v.resp_mode = resp_mode; v.lat = lat; v.nreq = nreq;
    v.eaddr = eaddr; v.ewr = ewr; v.emask = emask; v.ewdata = ewdata; v.edata = edata;
    v.eerr = eerr; v.emis = emis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Issue one request on instance sel (0=main, 1=timeout-4), driving ready from the vector's schedule.
  task automatic do_txn(input int sel, input vec_t v, input string nm);
    int          lat, nreq;
    logic [31:0] a_addr, a_wdata, a_data;
    logic [3:0]  a_mask;
    logic        a_wr, a_err, a_mis, a_rdy, stall_ok, rd;
    logic        c_req, c_valid, c_stall;
    lat = 0; nreq = 0; a_addr = '0; a_wdata = '0; a_data = '0; a_mask = '0;
    a_wr = 0; a_err = 0; a_mis = 0; a_rdy = 0; stall_ok = 1;
    @(negedge clk);
    req_write = v.wr; req_size = v.size; req_unsigned = v.uns; req_addr = v.addr;
    req_wdata = v.wdata; dmem_rdata = v.rdata; dmem_resp = 0; dmem_ready = 0; t_ready = 0;
    if (sel == 0) req_valid = 1; else t_valid = 1;
    #1;
    chk({nm, "_accept_ready"}, (sel == 0) ? req_ready : t_req_ready, 1);
    chk({nm, "_idle_stall"}, (sel == 0) ? stall : t_stall, 1);
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 0; t_valid = 0;
      rd = (k == v.rqw + 1) || (k == v.rqw + v.wtw + 2);
      if (sel == 0) dmem_ready = rd; else t_ready = rd;
      dmem_resp = (v.resp_mode == 1) || (v.resp_mode == 2 && k <= v.rqw + 1);
      #1;
      c_req   = (sel == 0) ? dreq : t_dreq;
      c_valid = (sel == 0) ? rsp_valid : t_rsp_valid;
      c_stall = (sel == 0) ? stall : t_stall;
      if (c_req) nreq++;
      if (k == 1 && c_req) begin
        a_addr  = (sel == 0) ? daddr : t_daddr;
        a_wr    = (sel == 0) ? dwr : t_dwr;
        a_mask  = (sel == 0) ? dmask : t_dmask;
        a_wdata = (sel == 0) ? dwdata : t_dwdata;
      end
      if (c_valid) begin
        lat   = k;
        a_data = (sel == 0) ? rsp_data : t_rsp_data;
        a_err  = (sel == 0) ? rsp_err : t_rsp_err;
        a_mis  = (sel == 0) ? misalign : t_misalign;
        a_rdy  = (sel == 0) ? req_ready : t_req_ready;
        if (c_stall) stall_ok = 0;
        break;
      end else if (!c_stall) stall_ok = 0;
    end
    if (lat == 0) begin
      n_total++;
      $display("FAIL %s_no_response: got none within 40 cycles expected rsp_valid", nm);
    end
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_req_cycles"}, nreq, v.nreq);
    if (v.nreq > 0) begin
      chk({nm, "_addr"}, a_addr, v.eaddr);
      chk({nm, "_wr"}, a_wr, v.ewr);
      chk({nm, "_mask"}, a_mask, v.emask);
      chk({nm, "_wdata"}, a_wdata, v.ewdata);
    end
    chk({nm, "_rsp_data"}, a_data, v.edata);
    chk({nm, "_rsp_err"}, a_err, v.eerr);
    chk({nm, "_stall"}, stall_ok, 1);
    chk({nm, "_done_ready"}, a_rdy, 0);
`ifdef MSRV32_MISALIGN_TRAP_EN
    chk({nm, "_misalign"}, a_mis, v.emis);
`endif
    @(negedge clk);
    dmem_ready = 0; t_ready = 0; dmem_resp = 0;
    #1;
    chk({nm, "_after_ready"}, (sel == 0) ? req_ready : t_req_ready, 1);
    chk({nm, "_after_valid"}, (sel == 0) ? rsp_valid : t_rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    vecs.push_back(mk(0, 2'b00, 0, 32'h103, 0, 32'h80AABBCC, 0, 0, 0, 3, 1, 32'h103, 0, 4'h0, 0, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h202, 0, 32'h92345678, 0, 0, 0, 3, 1, 32'h202, 0, 4'h0, 0, 32'h00009234, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 0, 0, 0, 3, 1, 32'h202, 1, 4'b1100, 32'hABCDABCD, 0, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h40, 32'h12345678, 0, 3, 2, 0, 8, 4, 32'h40, 1, 4'hF, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h80, 0, 32'hDEADBEEF, 0, 0, 1, 3, 1, 32'h80, 0, 4'h0, 0, 0, 1, 0));
`ifdef MSRV32_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h81, 0, 32'h11223344, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 1, 1));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h81, 0, 32'h11223344, 0, 0, 0, 3, 1, 32'h80, 0, 4'h0, 0, 32'h11223344, 0, 0));
`endif
    vecs.push_back(mk(0, 2'b01, 0, 32'h102, 0, 32'h80017FFF, 0, 0, 0, 3, 1, 32'h102, 0, 4'h0, 0, 32'hFFFF8001, 0, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h101, 0, 32'h1234F0AB, 0, 0, 0, 3, 1, 32'h101, 0, 4'h0, 0, 32'h000000F0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h003, 32'h123456C3, 0, 1, 0, 0, 4, 2, 32'h003, 1, 4'b1000, 32'hC3C3C3C3, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 32'h10, 0, 32'h87654321, 1, 0, 2, 4, 2, 32'h10, 0, 4'h0, 0, 32'h87654321, 0, 0));
`ifdef MSRV32_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 2'b01, 0, 32'h205, 0, 32'h1234F00D, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 1, 1));
`else
    vecs.push_back(mk(0, 2'b01, 0, 32'h205, 0, 32'h1234F00D, 0, 0, 0, 3, 1, 32'h204, 0, 4'h0, 0, 32'hFFFFF00D, 0, 0));
`endif
    vecs.push_back(mk(1, 2'b01, 0, 32'h000, 32'h5555BEEF, 0, 0, 1, 0, 4, 1, 32'h000, 1, 4'b0011, 32'hBEEFBEEF, 0, 0, 0));

    rst = 1; req_valid = 0; t_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; dmem_ready = 0; t_ready = 0; dmem_resp = 0; dmem_rdata = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dmem_req", dreq, 0);
    chk("rst_addr", daddr, 0);
    chk("rst_mask", dmask, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("rel_req_ready", req_ready, 1);

    foreach (vecs[i]) do_txn(0, vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while in WAIT abandons the transaction.
    @(negedge clk);
    req_write = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h300; dmem_rdata = 32'hCAFEF00D;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0; dmem_ready = 1;
    #1;
    chk("rstw_in_req", dreq, 1);
    @(negedge clk);
    dmem_ready = 0;
    #1;
    chk("rstw_in_wait", dreq, 0);
    chk("rstw_wait_stall", stall, 1);
    rst = 1;
    @(negedge clk);
    #1;
    chk("rstw_dmem_req", dreq, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_stall", stall, 0);
    chk("rstw_ready_in_rst", req_ready, 0);
    rst = 0;
    @(negedge clk);
    #1;
    chk("rstw_ready_after", req_ready, 1);
    chk("rstw_no_rsp", rsp_valid, 0);
    do_txn(0, mk(0, 2'b00, 0, 32'h302, 0, 32'h00C50000, 0, 0, 0, 3, 1, 32'h302, 0, 4'h0, 0, 32'hFFFFFFC5, 0, 0), "post_rst");

    // Timeout instance: ready never high, then ready arriving in the final cycle.
    do_txn(1, mk(0, 2'b10, 0, 32'h80, 0, 32'hAAAA5555, 1000, 0, 0, 5, 4, 32'h80, 0, 4'h0, 0, 0, 1, 0), "timeout");
    do_txn(1, mk(0, 2'b10, 0, 32'h84, 0, 32'h0BADF00D, 3, 0, 0, 6, 4, 32'h84, 0, 4'h0, 0, 32'h0BADF00D, 0, 0), "ready_wins");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
